dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter sharing the single data SRAM (11-bit word address, 32-bit data) between the pipelined CPU's data port and a secondary DMA/loader port. It muxes address, write data and write enable onto the SRAM, returns registered read data with a one-cycle valid strobe to the granted requester, and raises a stall to the CPU when the CPU loses arbitration. Locked DMA bursts are bounded so the CPU is never starved.

## Interface
- AW, 11, word address width (SRAM depth 2^AW words)
- DW, 32, data width
- MAX_BURST, 8, maximum consecutive locked DMA beats (>= 1)

- clk_in  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- c_req  input  1  CPU data access request (read or write)
- c_we  input  1  CPU write (1) / read (0), qualified by c_req
- c_addr  input  AW  CPU word address
- c_wdata  input  DW  CPU write data
- c_gnt  output  1  CPU access performed this cycle
- c_stall  output  1  c_req & ~c_gnt; freezes CPU pipeline
- c_rvalid  output  1  CPU read data valid (one cycle after read grant)
- c_rdata  output  DW  CPU read data, held until next CPU read completes
- d_req, d_we, d_addr, d_wdata  input  1/1/AW/DW  DMA request, same meaning as CPU
- d_lock  input  1  DMA requests burst ownership
- d_gnt, d_rvalid, d_rdata  output  1/1/DW  DMA grant/read-valid/read-data
- mem_a  output  AW  SRAM address
- mem_d  output  DW  SRAM write data
- mem_we  output  1  SRAM write enable
- mem_rdata  input  DW  SRAM asynchronous read data (for mem_a)

## Operation
- One access per cycle; winner chosen combinationally from current requests and registered state.
- States: IDLE (no owner lock), LOCKED (DMA owns the port).
- IDLE arbitration: only one requester -> it wins; both -> policy (see Configuration).
- IDLE -> LOCKED when d_gnt & d_lock; beat counter loaded with 1.
- In LOCKED: DMA wins whenever d_req & d_lock & count < MAX_BURST; count increments per d_gnt.
- LOCKED -> IDLE when d_lock=0, d_req=0, or count reaches MAX_BURST. Exit cycle is arbitrated as IDLE; after a MAX_BURST exit, CPU has priority for that cycle regardless of policy.
- mem_a/mem_d select the winner; with no winner, mem_a = c_addr, mem_d = 0.
- mem_we = winner's we & its gnt; never 1 without a grant.
- Read: on x_gnt & ~x_we, mem_rdata is registered into x_rdata and x_rvalid pulses next cycle. Writes produce no rvalid.
- c_gnt and d_gnt are mutually exclusive; never asserted without matching req.

## Timing
- Grant latency: 0 cycles (same-cycle combinational grant).
- Write: SRAM written at rising edge ending the grant cycle.
- Read latency: data/valid one cycle after grant; back-to-back reads give one word per cycle.
- Read after write to same address in consecutive cycles returns the new data.
- Reset (reset=0, asynchronous): state IDLE, count 0, round-robin pointer = CPU-last, c_rvalid=d_rvalid=0, c_rdata=d_rdata=0; c_gnt, d_gnt, mem_we forced 0 while reset is low; c_stall = c_req.
- Reset mid-burst drops the lock; any in-flight rvalid is cancelled.

## Configuration
- DMEM_ARB_RR_EN defined: IDLE contention resolved round-robin; a 1-bit last-winner register flips to the loser's side, so alternate cycles alternate owners.
- Undefined: fixed priority, CPU always wins IDLE contention; DMA is served only in idle CPU cycles or via LOCKED bursts.

## Test plan
- CPU only: write 0xDEADBEEF to addr 0x010, read 0x010 next cycle -> c_gnt=1 both cycles, c_stall=0, c_rvalid=1 with c_rdata=0xDEADBEEF one cycle after read.
- Contention without lock, macro undefined: both req for 4 cycles -> c_gnt=1 all 4, d_gnt=0, c_stall=0; with DMEM_ARB_RR_EN -> grants alternate DMA, CPU, DMA, CPU (after reset), c_stall=1 on DMA cycles.
- Locked burst, MAX_BURST=8: d_lock=1, d_req=1, c_req=1 for 12 cycles -> d_gnt for cycles 0-7, c_gnt at cycle 8, c_stall=1 for cycles 0-7.
- Lock release: d_lock drops after 3 beats -> state returns to IDLE, CPU granted next contention cycle per policy.
- Reset mid-burst at beat 5 with a read in flight -> gnts, mem_we, rvalids go 0 immediately; after release, CPU-only request granted in first cycle.
- No-request cycles: mem_we=0, both gnt=0, rvalids 0, rdata registers unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data SRAM between the CPU data port (c_*) and a
// secondary DMA/loader port (d_*). One access is performed per cycle. The
// winner is chosen combinationally from the current requests and the
// registered arbitration state. Read data is captured one cycle after the
// grant and returned with a one-cycle valid strobe to the port that issued
// the read.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> IDLE contention is resolved round-robin
//                   undefined -> fixed priority, the CPU wins IDLE contention
//
// Ports:
//   clk_in            system clock, all state changes on the rising edge
//   reset             asynchronous, active-low reset
//   c_req/c_we        CPU request / write(1)-read(0)
//   c_addr/c_wdata    CPU word address / write data
//   c_gnt             CPU access performed this cycle
//   c_stall           c_req & ~c_gnt, freezes the CPU pipeline
//   c_rvalid/c_rdata  CPU read strobe / read data (held until next CPU read)
//   d_req/d_we/d_addr/d_wdata   DMA request, same meaning as the CPU side
//   d_lock            DMA asks for burst ownership
//   d_gnt/d_rvalid/d_rdata      DMA grant / read strobe / read data
//   mem_a/mem_d/mem_we          SRAM address / write data / write enable
//   mem_rdata         SRAM asynchronous read data for mem_a
//   dbg_state         current arbitration state (0 = IDLE, 1 = LOCKED)
//
// Handshake: a request (x_req) is held by the requester until it observes
// x_gnt high in the same cycle; the access completes in that cycle, there is
// no ready/backpressure beyond the grant. x_rvalid is a single-cycle strobe
// and is never stalled.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk_in,
  input  logic          reset,
  // CPU port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // DMA port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_lock,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // SRAM side
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  // debug
  output logic [0:0]    dbg_state
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Counter must be able to hold MAX_BURST itself.
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  logic [0:0]    state;
  logic [CW-1:0] count;

  logic lock_win;   // DMA keeps the port as part of a locked burst
  logic cpu_first;  // CPU wins if both request during IDLE-style arbitration
  logic c_win;
  logic d_win;

`ifdef DMEM_ARB_RR_EN
  // 1 = DMA was the last port granted. Reset points at the CPU, so the
  // first contended cycle after reset goes to the DMA.
  logic last_dma;
  logic burst_done;

  // A burst that ran to MAX_BURST hands the exit cycle to the CPU regardless
  // of the round-robin pointer, so a streaming DMA cannot starve the CPU.
  assign burst_done = (state == ST_LOCKED) && (count >= MAX_CNT);
  assign cpu_first  = last_dma | burst_done;
`else
  assign cpu_first  = 1'b1;
`endif

  assign lock_win = (state == ST_LOCKED) && d_req && d_lock && (count < MAX_CNT);

  // Winner selection. Outside a live locked beat (including the cycle the
  // lock is being released) the cycle is arbitrated exactly like IDLE.
  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (lock_win) begin
      d_win = 1'b1;
    end else if (c_req && d_req) begin
      c_win = cpu_first;
      d_win = ~cpu_first;
    end else begin
      c_win = c_req;
      d_win = d_req;
    end
  end

  // Grants are forced low combinationally while reset is held.
  assign c_gnt   = c_win & reset;
  assign d_gnt   = d_win & reset;
  assign c_stall = c_req & ~c_gnt;

  // SRAM mux. With no winner the address parks on the CPU address and the
  // write data is zeroed; mem_we can only be high alongside a grant.
  assign mem_a  = d_gnt ? d_addr : c_addr;
  assign mem_d  = c_gnt ? c_wdata : (d_gnt ? d_wdata : '0);
  assign mem_we = (c_gnt & c_we) | (d_gnt & d_we);

  assign dbg_state = state;

  // Arbitration state and burst beat counter.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (lock_win) begin
      state <= ST_LOCKED;
      count <= count + ONE_CNT;
    end else if (d_gnt && d_lock) begin
      // Fresh lock: this grant is beat 1 of the burst.
      state <= ST_LOCKED;
      count <= ONE_CNT;
    end else begin
      state <= ST_IDLE;
      count <= '0;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      last_dma <= 1'b0;
    end else if (c_gnt || d_gnt) begin
      last_dma <= d_gnt;
    end
  end
`endif

  // Read return path. Data registers only update on a read grant so the
  // last word stays visible between reads.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      c_rvalid <= 1'b0;
      c_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt & ~c_we;
      if (c_gnt && !c_we) begin
        c_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= d_gnt & ~d_we;
      if (d_gnt && !d_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule
